micro: RTL and testbench



---
 rtl/micro_pkg.sv | 50 +++++
 rtl/micro_alu.sv | 31 +++
 rtl/micro.sv | 88 ++++++++
 tb/tb_micro.sv | 129 ++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// micro_pkg: field positions and encodings for the micro instruction word.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Shared by micro (decoder/registers) and micro_alu (add/sub datapath).
package micro_pkg;

    localparam int DATA_W = 8;

    // Instruction field positions
    localparam int CLASS_HI = 7;
    localparam int CLASS_LO = 6;
    localparam int OP_BIT   = 5;
    localparam int OPD_HI   = 4;
    localparam int OPD_LO   = 3;
    localparam int DST_HI   = 5;
    localparam int DST_LO   = 3;
    localparam int SRC_HI   = 2;
    localparam int SRC_LO   = 0;

    // Instruction classes (inst[7:6]); 1x is NOP
    localparam logic [1:0] CLS_MOVE = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;

    // Move destinations (inst[5:3]); 101-111 are NOP
    localparam logic [2:0] DST_NONE = 3'b000;
    localparam logic [2:0] DST_A    = 3'b001;
    localparam logic [2:0] DST_B    = 3'b010;
    localparam logic [2:0] DST_C    = 3'b011;
    localparam logic [2:0] DST_OUT  = 3'b100;

    // Output-transfer sources (inst[2:0]); 000 and 101-111 are NOP
    localparam logic [2:0] SRC_NONE = 3'b000;
    localparam logic [2:0] SRC_A    = 3'b001;
    localparam logic [2:0] SRC_B    = 3'b010;
    localparam logic [2:0] SRC_C    = 3'b011;
    localparam logic [2:0] SRC_IN   = 3'b100;

    // ALU operand select (inst[4:3])
    localparam logic [1:0] OPD_IN = 2'b00;
    localparam logic [1:0] OPD_B  = 2'b01;
    localparam logic [1:0] OPD_C  = 2'b10;
    localparam logic [1:0] OPD_A  = 2'b11;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/micro_alu.sv
// micro_alu: combinational 8-bit add/sub, y = a op x, modulo 256, no flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: a, x (operands), op (OP_ADD/OP_SUB), y (result).
// Config: MICRO_ALU_SUB_EN builds the subtract path; without it op is
// ignored and every operation adds.
module micro_alu
    import micro_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] x,
    input  op_t               op,
    output logic [DATA_W-1:0] y
);

`ifdef MICRO_ALU_SUB_EN
    always_comb begin
        y = a + x;
        if (op == OP_SUB) begin
            y = a - x;
        end
    end
`else
    // Opcode bit has no effect when the subtractor is not built.
    logic unused_op;
    assign unused_op = op;
    assign y = a + x;
`endif

endmodule

// File: rtl/micro.sv
// micro: 8-bit accumulator core, one instruction per clock, registers A/B/C + data_out.
// Latency: 1 cycle; results visible right after the sampling edge.
// Backpressure: none; an instruction is consumed on every rising edge.
//
// Ports: clk, rst (sync, active-high), inst[7:0], data_in[7:0], data_out[7:0] (registered).
// Config: MICRO_ALU_SUB_EN enables subtraction for ALU instructions with inst[5]=1.
module micro
    import micro_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        inst,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out
);

    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] reg_c;

    logic [1:0]        cls;
    logic [1:0]        opd;
    logic [2:0]        dst;
    logic [2:0]        src;
    op_t               op;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;

    assign cls = inst[CLASS_HI:CLASS_LO];
    assign opd = inst[OPD_HI:OPD_LO];
    assign dst = inst[DST_HI:DST_LO];
    assign src = inst[SRC_HI:SRC_LO];
    assign op  = op_t'(inst[OP_BIT]);

    // Operand mux reads pre-edge register values, so X = A gives 2A.
    always_comb begin
        alu_x = data_in;
        case (opd)
            OPD_B:   alu_x = reg_b;
            OPD_C:   alu_x = reg_c;
            OPD_A:   alu_x = reg_a;
            default: alu_x = data_in;
        endcase
    end

    micro_alu u_alu (
        .a  (reg_a),
        .x  (alu_x),
        .op (op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            data_out <= '0;
        end else begin
            case (cls)
                CLS_ALU: begin
                    reg_a <= alu_y;
                end
                CLS_MOVE: begin
                    case (dst)
                        DST_A:   reg_a    <= data_in;
                        DST_B:   reg_b    <= data_in;
                        DST_C:   reg_c    <= data_in;
                        DST_OUT: data_out <= data_in;
                        DST_NONE: begin
                            // Output transfer: source field only meaningful here.
                            case (src)
                                SRC_A:   data_out <= reg_a;
                                SRC_B:   data_out <= reg_b;
                                SRC_C:   data_out <= reg_c;
                                SRC_IN:  data_out <= data_in;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_micro.sv
// tb_micro: directed-vector bench for micro; internal registers are observed
// through output-transfer instructions. Expected values are hand-computed and
// depend on MICRO_ALU_SUB_EN where subtraction is involved.
module tb_micro;

    logic       clk;
    logic       rst;
    logic [7:0] inst;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_vec;
    int n_bad;

`ifdef MICRO_ALU_SUB_EN
    localparam logic [7:0] EXP_SUB_5F_55 = 8'h0A;  // 0x5F - 0x55
    localparam logic [7:0] EXP_SUB_00_01 = 8'hFF;  // 0x00 - 0x01 wraps
`else
    localparam logic [7:0] EXP_SUB_5F_55 = 8'hB4;  // adds instead: 0x5F + 0x55
    localparam logic [7:0] EXP_SUB_00_01 = 8'h01;  // adds instead: 0x00 + 0x01
`endif

    micro dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: data_out=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // Apply one instruction, let it be sampled, then settle 1 time unit past the edge.
    task automatic step(input logic [7:0] i, input logic [7:0] d);
        inst    = i;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        inst    = 8'h00;
        data_in = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_out", data_out, 8'h00);
        rst = 1'b0;

        // NOP output transfer after reset
        step(8'h00, 8'h33); chk("nop00_out", data_out, 8'h00);
        step(8'h01, 8'h33); chk("rst_a",     data_out, 8'h00);
        step(8'h02, 8'h33); chk("rst_b",     data_out, 8'h00);
        step(8'h03, 8'h33); chk("rst_c",     data_out, 8'h00);

        // Load B, then transfer it out
        step(8'h12, 8'h55); chk("ldb_out_hold", data_out, 8'h00);
        step(8'h02, 8'h00); chk("out_b",        data_out, 8'h55);

        // ALU: load, add B, subtract B
        step(8'h08, 8'h0A); step(8'h01, 8'h00); chk("lda",     data_out, 8'h0A);
        step(8'h48, 8'h00); step(8'h01, 8'h00); chk("add_b",   data_out, 8'h5F);
        step(8'h68, 8'h00); step(8'h01, 8'h00); chk("sub_b",   data_out, EXP_SUB_5F_55);

        // Wrap-around
        step(8'h08, 8'hFF); step(8'h40, 8'h01); step(8'h01, 8'h00);
        chk("add_wrap", data_out, 8'h00);
        step(8'h60, 8'h01); step(8'h01, 8'h00);
        chk("sub_wrap", data_out, EXP_SUB_00_01);

        // C path and NOPs
        step(8'h18, 8'h77); step(8'h03, 8'h00); chk("out_c",   data_out, 8'h77);
        step(8'h80, 8'h99); chk("nop80",  data_out, 8'h77);
        step(8'h05, 8'h99); chk("nop05",  data_out, 8'h77);
        step(8'h01, 8'h99); chk("keep_a", data_out, EXP_SUB_00_01);
        step(8'h02, 8'h99); chk("keep_b", data_out, 8'h55);
        step(8'h03, 8'h99); chk("keep_c", data_out, 8'h77);

        // data_in to data_out via destination 100 and source 100; dst 101 is NOP
        step(8'h20, 8'hC3); chk("dst_out", data_out, 8'hC3);
        step(8'h04, 8'h3C); chk("src_in",  data_out, 8'h3C);
        step(8'h28, 8'h11); chk("dst101",  data_out, 8'h3C);
        step(8'h03, 8'h00); chk("dst101_c", data_out, 8'h77);

        // A + A uses the pre-edge value of A
        step(8'h08, 8'h81); step(8'h58, 8'h00); step(8'h01, 8'h00);
        chk("add_a", data_out, 8'h02);
        step(8'h07, 8'h5A); chk("src111", data_out, 8'h02);

        // Nonzero destination ignores inst[2:0]
        step(8'h11, 8'h66); chk("dst_ign_src", data_out, 8'h02);
        step(8'h02, 8'h00); chk("ldb2",        data_out, 8'h66);

        // X = C, and X = data_in with nonzero inst[2:0]
        step(8'h50, 8'h00); step(8'h01, 8'h00); chk("add_c",  data_out, 8'h79);
        step(8'h47, 8'h10); step(8'h01, 8'h00); chk("add_in", data_out, 8'h89);

        // Reset mid-stream overrides a concurrent output transfer
        step(8'h12, 8'h55);
        rst = 1'b1;
        step(8'h02, 8'h00); chk("rst_mid", data_out, 8'h00);
        rst = 1'b0;
        step(8'h02, 8'h00); chk("post_rst_b", data_out, 8'h00);
        step(8'h04, 8'hA5); chk("post_rst_in", data_out, 8'hA5);
        step(8'h01, 8'h00); chk("post_rst_a",  data_out, 8'h00);
        step(8'h03, 8'h00); chk("post_rst_c",  data_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
